hms_sw_ctrl: RTL
================

// Module: hms_sw_ctrl
// PURPOSE
//  Front-end controller for the HMS clock: synchronises and debounces three active-low pushbuttons,
//  runs the CLOCK/SETUP mode FSM, and issues single-cycle count-enable pulses (sec/min/hour) to the
//  downstream HMS counters. It sits directly upstream of the counters.
//  Everything runs on the single system clock, with no derived clocks.
//  Also drives setup-position status and a blink flag for the display stage.
// PARAMETERS
//  TICK_DIV   50_000_000  system-clock cycles per 1 s tick (>=4)
//  DB_CYC     500_000     consecutive stable cycles required to accept a switch level change (>=1)
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst_n          in   1  asynchronous active-low reset
//  i_sw0          in   1  mode button, active-low (0 = pressed), asynchronous to clk
//  i_sw1          in   1  position button, active-low
//  i_sw2          in   1  increment button, active-low
//  i_max_hit_sec  in   1  1-cycle pulse from sec counter, coincident with its 59->0 wrap
//  i_max_hit_min  in   1  1-cycle pulse from min counter, coincident with its 59->0 wrap
//  o_mode         out  1  0 = MODE_CLOCK, 1 = MODE_SETUP
//  o_position     out  2  0 = POS_SEC, 1 = POS_MIN, 2 = POS_HOUR (3 never driven)
//  o_sec_tick     out  1  1-cycle sec count enable
//  o_min_tick     out  1  1-cycle min count enable
//  o_hour_tick    out  1  1-cycle hour count enable
//  o_blink        out  1  display blink flag for the selected field
// BEHAVIOUR
//  Reset: o_mode=CLOCK, o_position=SEC, all ticks=0, o_blink=0. Synchroniser and stable levels=1.
//    Debounce and tick counters=0. Reset mid-operation aborts any pending debounce or tick.
//  Input path, per switch: 2-FF synchroniser, then debounce.
//    Debounce counter clears whenever the synced value equals the stable level.
//    Otherwise it increments. When it reaches DB_CYC, the stable level takes the synced value and the counter clears.
//  Press event: 1-cycle internal pulse on a stable 1->0 transition. No event on release.
//    No auto-repeat: a button held for any time gives exactly one event.
//  Latency: from an i_swN fall to its registered output effect is exactly DB_CYC+3 cycles.
//  Tick generator: tcnt counts 0..TICK_DIV-1 and wraps. tick_1hz=1 in the cycle tcnt==TICK_DIV-1.
//    tcnt clears on every SETUP->CLOCK transition, so the first second after setup is full length.
//  FSM {CLOCK, SETUP}:
//    sw0 event toggles the mode.
//    Entering SETUP forces o_position=SEC.
//    In CLOCK, sw1 and sw2 events are ignored.
//    In SETUP, sw1 event advances the position SEC->MIN->HOUR->SEC.
//  Tick outputs are registered, 1 cycle after their source:
//    CLOCK: o_sec_tick<=tick_1hz, o_min_tick<=i_max_hit_sec, o_hour_tick<=i_max_hit_min.
//    SETUP: tick_1hz and both i_max_hit inputs are ignored (no carries while setting).
//      An sw2 event pulses only the tick of the selected position.
//  Simultaneous events:
//    sw0 with sw1/sw2 in the same cycle: the mode toggle wins and sw1/sw2 are dropped.
//    sw1+sw2 in SETUP: the increment uses the OLD position, then the position advances.
//  o_blink: 0 in CLOCK. In SETUP, o_blink = (tcnt < TICK_DIV/2), registered, with tcnt free-running.
//  At most one of the three tick outputs is high in any cycle during SETUP.
//    In CLOCK they follow their sources and may overlap.
// STRUCTURE
//  Shared include hms_defs.vh: MODE_CLOCK/MODE_SETUP, POS_SEC/POS_MIN/POS_HOUR, position width.
//  Sub-module sw_debounce (params DB_CYC): synchroniser + debounce + fall-edge event.
//    Instantiated 3x. Ports: clk, rst_n, i_sw, o_level, o_press.
//  Top: FSM, tick/blink counter, output registers.
// TESTING (TICK_DIV=10, DB_CYC=4)
//  1 Reset, CLOCK idle.
//    Expect o_sec_tick pulses every 10 cycles.
//    Pulse i_max_hit_sec -> o_min_tick=1 exactly the next cycle.
//    Pulse i_max_hit_min -> o_hour_tick=1 exactly the next cycle.
//  2 Bounce: i_sw0 low 3 cycles, then high -> no mode change.
//    Low 20 cycles -> o_mode=SETUP at cycle 7 after the fall. Release -> no further change.
//  3 SETUP: sw1 x2 -> o_position=HOUR. sw2 -> one o_hour_tick; sec/min ticks stay 0.
//    sw1 -> SEC. Hold sw2 100 cycles -> exactly one o_sec_tick.
//  4 SETUP: i_max_hit_sec/min pulses and the 1 s rollover -> no tick outputs.
//    o_blink toggles with period 10. sw0 -> CLOCK, o_blink=0, first o_sec_tick 10 cycles later.
//  5 Same cycle:
//    sw1+sw2 at POS_MIN -> o_min_tick pulse and o_position=HOUR.
//    sw0+sw2 in SETUP -> mode=CLOCK and no tick.
//  6 Assert rst_n low mid-debounce and mid-SETUP -> all outputs return to reset values immediately.
//    No tick output follows after the release of rst_n.

Source files
------------

// File: rtl/hms_sw_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hms_sw_ctrl_pkg
//   Shared definitions for the HMS clock front-end controller: mode and
//   setup-position encodings, switch indices, and the position-advance helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package hms_sw_ctrl_pkg;

    localparam int POS_W  = 2;
    localparam int NUM_SW = 3;

    // Mode encoding (o_mode)
    localparam logic MODE_CLOCK = 1'b0;
    localparam logic MODE_SETUP = 1'b1;

    // Setup position encoding (o_position); 3 is never driven
    localparam logic [POS_W-1:0] POS_SEC  = 2'd0;
    localparam logic [POS_W-1:0] POS_MIN  = 2'd1;
    localparam logic [POS_W-1:0] POS_HOUR = 2'd2;

    // Switch index within the packed switch vector
    localparam int SW_MODE = 0;
    localparam int SW_POS  = 1;
    localparam int SW_INC  = 2;

    // SEC -> MIN -> HOUR -> SEC; an illegal code recovers to SEC
    function automatic logic [POS_W-1:0] pos_next(input logic [POS_W-1:0] pos);
        case (pos)
            POS_SEC: return POS_MIN;
            POS_MIN: return POS_HOUR;
            default: return POS_SEC;
        endcase
    endfunction

endpackage

// File: rtl/hms_sw_ctrl_sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
//   One active-low pushbutton: 2-FF synchroniser, level debounce, and a
//   single-cycle press pulse on an accepted 1->0 level change.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     i_sw     in   raw button, active-low, asynchronous to clk
//     o_level  out  debounced level (1 = released)
//     o_press  out  1-cycle pulse, registered in the same edge the level falls
// ----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DB_CYC = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_level,
    output logic o_press
);

    // Counter only has to reach DB_CYC-1; the DB_CYC-th mismatching cycle
    // is the one that accepts the new level.
    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = r_sync[1] ^ r_level;
    assign w_done = w_diff && (r_cnt == CW'(DB_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_sw};
            // Accepting a change while the stable level is 1 means a press;
            // releases never produce an event, so holding gives one pulse.
            r_press <= w_done && r_level;
            if (!w_diff || w_done) r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
            if (w_done) r_level <= r_sync[1];
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/hms_sw_ctrl.sv
// ----------------------------------------------------------------------------
// hms_sw_ctrl
//   Front-end controller for the HMS clock. Debounces three active-low
//   buttons, runs the CLOCK/SETUP mode FSM and issues 1-cycle count enables
//   to the sec/min/hour counters. Also drives setup position and blink flag.
//   Ports:
//     clk, rst_n          system clock, async active-low reset
//     i_sw0/1/2           mode / position / increment buttons (active-low)
//     i_max_hit_sec/min   carry pulses from the sec / min counters
//     o_mode              0 = CLOCK, 1 = SETUP
//     o_position          0 = SEC, 1 = MIN, 2 = HOUR
//     o_sec/min/hour_tick 1-cycle count enables
//     o_blink             display blink flag (SETUP only)
// ----------------------------------------------------------------------------
module hms_sw_ctrl
    import hms_sw_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DB_CYC   = 500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sw0,
    input  logic             i_sw1,
    input  logic             i_sw2,
    input  logic             i_max_hit_sec,
    input  logic             i_max_hit_min,
    output logic             o_mode,
    output logic [POS_W-1:0] o_position,
    output logic             o_sec_tick,
    output logic             o_min_tick,
    output logic             o_hour_tick,
    output logic             o_blink
);

    localparam int TW = $clog2(TICK_DIV);

    logic [NUM_SW-1:0] w_sw;
    logic [NUM_SW-1:0] w_level;
    logic [NUM_SW-1:0] w_press;
    logic              w_unused_level;

    assign w_sw = {i_sw2, i_sw1, i_sw0};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_db
        sw_debounce #(.DB_CYC(DB_CYC)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_sw    (w_sw[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    // Stable levels are not needed here; only the press events drive the FSM.
    assign w_unused_level = ^w_level;

    logic             r_mode;
    logic [POS_W-1:0] r_pos;
    logic [TW-1:0]    r_tcnt;
    logic             r_sec_tick;
    logic             r_min_tick;
    logic             r_hour_tick;
    logic             r_blink;

    logic             w_mode_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_inc;
    logic             w_exit_setup;
    logic             w_tick_1hz;

    // Mode toggle has priority: sw1/sw2 in the same cycle are dropped.
    // sw1+sw2 together: the increment sees the old position (w_inc uses r_pos).
    always_comb begin
        w_mode_nxt = r_mode;
        w_pos_nxt  = r_pos;
        w_inc      = 1'b0;
        if (w_press[SW_MODE]) begin
            w_mode_nxt = ~r_mode;
            if (r_mode == MODE_CLOCK) w_pos_nxt = POS_SEC;
        end else if (r_mode == MODE_SETUP) begin
            w_inc = w_press[SW_INC];
            if (w_press[SW_POS]) w_pos_nxt = pos_next(r_pos);
        end
    end

    assign w_exit_setup = w_press[SW_MODE] && (r_mode == MODE_SETUP);
    assign w_tick_1hz   = (r_tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_CLOCK;
            r_pos       <= POS_SEC;
            r_tcnt      <= '0;
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_pos  <= w_pos_nxt;

            // Restart the second on leaving SETUP so the first one is full length.
            if (w_exit_setup || w_tick_1hz) r_tcnt <= '0;
            else                            r_tcnt <= r_tcnt + 1'b1;

            if (r_mode == MODE_CLOCK) begin
                r_sec_tick  <= w_tick_1hz;
                r_min_tick  <= i_max_hit_sec;
                r_hour_tick <= i_max_hit_min;
            end else begin
                // Carries and the 1 Hz tick are suppressed while setting.
                r_sec_tick  <= w_inc && (r_pos == POS_SEC);
                r_min_tick  <= w_inc && (r_pos == POS_MIN);
                r_hour_tick <= w_inc && (r_pos == POS_HOUR);
            end

            // Uses the next mode so blink drops in the same edge CLOCK is entered.
            r_blink <= (w_mode_nxt == MODE_SETUP) && (r_tcnt < TW'(TICK_DIV / 2));
        end
    end

    assign o_mode      = r_mode;
    assign o_position  = r_pos;
    assign o_sec_tick  = r_sec_tick;
    assign o_min_tick  = r_min_tick;
    assign o_hour_tick = r_hour_tick;
    assign o_blink     = r_blink;

endmodule
